// File: rtl/sram_pkg.sv
// sram_pkg -- shared types and helpers for the banked SRAM.
//   state_t     : controller state (INIT clears the array, READY serves requests)
//   byte_parity : even-parity bit for one byte (bit that makes the 9-bit total even)
package sram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic logic byte_parity(input logic [7:0] i_byte);
      return ^i_byte;
   endfunction

endpackage

// File: rtl/sram_bank.sv
// sram_bank -- one single-port, byte-enabled storage bank.
// Ports:
//   i_clk    : clock; writes land on the rising edge
//   i_we     : write enable for this bank
//   i_row    : row address (used for both write and read)
//   i_be     : per-byte write enable
//   i_wdata  : write data
//   o_rdata  : read data of i_row (combinational; the caller registers it)
//   i_wpar / o_rpar : per-byte check bits, present only with SRAM_PARITY_EN
// Build option: SRAM_PARITY_EN adds one stored parity bit per byte.
module sram_bank
   import sram_pkg::*;
#(
   parameter int ROW_W      = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_we,
   input  logic [ROW_W-1:0]        i_row,
   input  logic [DATA_WIDTH/8-1:0] i_be,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
`ifdef SRAM_PARITY_EN
   input  logic [DATA_WIDTH/8-1:0] i_wpar,
   output logic [DATA_WIDTH/8-1:0] o_rpar,
`endif
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int ROWS   = 2 ** ROW_W;

   // Storage carries no reset; the controller's INIT sweep clears it.
   logic [DATA_WIDTH-1:0] r_mem [ROWS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (i_be[k]) r_mem[i_row][k*8 +: 8] <= i_wdata[k*8 +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_row];

`ifdef SRAM_PARITY_EN
   logic [NBYTES-1:0] r_par [ROWS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (i_be[k]) r_par[i_row][k] <= i_wpar[k];
         end
      end
   end

   assign o_rpar = r_par[i_row];
`endif

endmodule

// File: rtl/sram_banked.sv
// sram_banked -- banked word SRAM with a two-stage request pipeline.
// Ports:
//   i_clk         : clock
//   i_reset       : asynchronous active-low reset
//   i_req_valid   : request present          o_req_ready : request accepted this cycle
//   i_req_write   : 1 = write, 0 = read      i_addr_sel  : word address
//   i_byte_sel    : per-byte write enable    i_datain    : write data
//   i_err_inject  : corrupt stored parity of written bytes (parity build only)
//   o_rsp_valid   : one-cycle read-data pulse
//   o_dataout     : read data, held between responses
//   o_rsp_err     : read data failed the parity check (qualified by o_rsp_valid)
// Build option: SRAM_PARITY_EN enables per-byte even parity.
// Timing: accept at E0, array access at E0+1, response visible after E0+1.
// Low address bits pick the bank, the upper bits the row.
module sram_banked
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BANKS  = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_write,
   input  logic [ADDR_WIDTH-1:0]   i_addr_sel,
   input  logic [DATA_WIDTH/8-1:0] i_byte_sel,
   input  logic [DATA_WIDTH-1:0]   i_datain,
   input  logic                    i_err_inject,
   output logic                    o_rsp_valid,
   output logic [DATA_WIDTH-1:0]   o_dataout,
   output logic                    o_rsp_err
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int BANK_W = $clog2(NUM_BANKS);
   localparam int ROW_W  = ADDR_WIDTH - BANK_W;
   localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);

   // ---------------- controller ----------------
   state_t           r_state;
   logic [ROW_W-1:0] r_row;
   logic             r_ready;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= INIT;
         r_row   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               // Row counter wraps to 0 on the last row and then stays there.
               r_row <= r_row + ROW_W'(1);
               if (r_row == '1) begin
                  r_state <= READY;
                  r_ready <= 1'b1;
               end
            end
            READY:   r_ready <= 1'b1;
            default: begin
               r_state <= INIT;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_req_ready = r_ready;

   logic w_init;
   logic w_accept;
   assign w_init   = (r_state == INIT);
   assign w_accept = i_req_valid & r_ready;

   // ---------------- request pipeline ----------------
   // r_vld_pipe[0]: request latched, array access this cycle
   // r_vld_pipe[1]: read response on the outputs
   logic [1:0]              r_vld_pipe;
   logic                    r_s1_write;
   logic [ADDR_WIDTH-1:0]   r_s1_addr;
   logic [NBYTES-1:0]       r_s1_be;
   logic [DATA_WIDTH-1:0]   r_s1_data;
   logic [DATA_WIDTH-1:0]   r_dataout;
   logic                    w_rd_fire;
   logic [DATA_WIDTH-1:0]   w_rsel;

   assign w_rd_fire = r_vld_pipe[0] & ~r_s1_write;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_vld_pipe <= '0;
         r_s1_write <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_be    <= '0;
         r_s1_data  <= '0;
         r_dataout  <= '0;
      end else begin
         r_vld_pipe[0] <= w_accept;
         r_vld_pipe[1] <= w_rd_fire;
         if (w_accept) begin
            r_s1_write <= i_req_write;
            r_s1_addr  <= i_addr_sel;
            r_s1_be    <= i_byte_sel;
            r_s1_data  <= i_datain;
         end
         if (w_rd_fire) r_dataout <= w_rsel;
      end
   end

   assign o_rsp_valid = r_vld_pipe[1];
   assign o_dataout   = r_dataout;

   // ---------------- bank array ----------------
   logic [ADDR_WIDTH-1:0] w_bank_a;
   logic [ROW_W-1:0]      w_s1_row;
   logic [ROW_W-1:0]      w_row;
   logic [NBYTES-1:0]     w_be;
   logic [DATA_WIDTH-1:0] w_wdata;

   assign w_bank_a = r_s1_addr & BANK_MASK;
   assign w_s1_row = ROW_W'(r_s1_addr >> BANK_W);

   // INIT owns the array: every bank writes zero to the sweep row.
   assign w_row   = w_init ? r_row : w_s1_row;
   assign w_be    = w_init ? '1    : r_s1_be;
   assign w_wdata = w_init ? '0    : r_s1_data;

   logic [NUM_BANKS-1:0]                 w_we;
   logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_rd;

`ifdef SRAM_PARITY_EN
   logic                             r_s1_inj;
   logic                             r_rsp_err;
   logic [NBYTES-1:0]                w_wpar;
   logic [NBYTES-1:0]                w_rpar_sel;
   logic [NBYTES-1:0]                w_rpar_calc;
   logic [NUM_BANKS-1:0][NBYTES-1:0] w_rpar;
`endif

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      assign w_we[g] = w_init |
                       (r_vld_pipe[0] & r_s1_write & (w_bank_a == ADDR_WIDTH'(g)));

      sram_bank #(
         .ROW_W      (ROW_W),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
         .i_clk   (i_clk),
         .i_we    (w_we[g]),
         .i_row   (w_row),
         .i_be    (w_be),
         .i_wdata (w_wdata),
`ifdef SRAM_PARITY_EN
         .i_wpar  (w_wpar),
         .o_rpar  (w_rpar[g]),
`endif
         .o_rdata (w_rd[g])
      );
   end

   always_comb begin
      w_rsel = '0;
`ifdef SRAM_PARITY_EN
      w_rpar_sel = '0;
`endif
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_bank_a == ADDR_WIDTH'(b)) begin
            w_rsel = w_rd[b];
`ifdef SRAM_PARITY_EN
            w_rpar_sel = w_rpar[b];
`endif
         end
      end
   end

   // ---------------- check bits ----------------
`ifdef SRAM_PARITY_EN
   for (genvar k = 0; k < NBYTES; k++) begin : g_par
      // Injection flips the stored bit so the next read of that byte mismatches.
      assign w_wpar[k]      = byte_parity(w_wdata[k*8 +: 8]) ^ (r_s1_inj & ~w_init);
      assign w_rpar_calc[k] = byte_parity(w_rsel[k*8 +: 8]);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_s1_inj  <= 1'b0;
         r_rsp_err <= 1'b0;
      end else begin
         if (w_accept) r_s1_inj <= i_err_inject;
         r_rsp_err <= w_rd_fire & (|(w_rpar_sel ^ w_rpar_calc));
      end
   end

   assign o_rsp_err = r_rsp_err;
`else
   logic w_unused_inj;
   assign w_unused_inj = i_err_inject;
   assign o_rsp_err    = 1'b0;
`endif

endmodule
